product_collector: RTL and testbench
====================================

# product_collector

Result-capture buffer at the output end of the multiplier datapath. It accepts one product per handshake from the operand controller/multiplier side and masks it to the active mode's width. Each product is stored with its mode tag in a DEPTH-entry in-order buffer, and a running XOR checksum is kept. A downstream reader (bench or host port) pops entries in order. Sticky error flags record dropped products and empty reads.

## Interface
- DEPTH, 16, number of buffer entries (power of two, ≥2)
- WIDTH, 128, product width (full mode-M4 width)
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; forces all state to reset values
- clear  input  1  synchronous clear of pointers, count, checksum, flags
- in_valid  input  1  product/mode valid this cycle
- in_ready  output  1  buffer can accept; = !full
- product  input  WIDTH  product from multiplier
- mode  input  2  0,1 → 64-bit result; 2 → 96-bit; 3 → 128-bit
- rd_req  input  1  pop oldest entry
- rd_valid  output  1  one-cycle pulse: rd_data/rd_mode hold popped entry
- rd_data  output  WIDTH  popped masked product (registered)
- rd_mode  output  2  mode tag of popped entry (registered)
- count  output  log2(DEPTH)+1  entries held
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky: in_valid while !in_ready
- underflow  output  1  sticky: rd_req while empty
- checksum  output  WIDTH  XOR of all accepted masked products since reset/clear

## Operation
- Push: when in_valid && in_ready, write {mode, product & mask(mode)} at wr_ptr. wr_ptr increments modulo DEPTH.
- mask(mode): modes 0/1 keep bits [63:0]; mode 2 keeps [95:0]; mode 3 keeps all 128; cleared bits are zero.
- checksum ^= masked product on every accepted push.
- Pop: when rd_req && !empty, register the entry at rd_ptr into rd_data/rd_mode and pulse rd_valid. rd_ptr increments modulo DEPTH.
- Occupancy states are derived from count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on a push without pop at DEPTH-1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on a pop without push at 1.
- Simultaneous push and pop in PARTIAL: both occur and count is unchanged.
- At FULL, in_ready=0, so a pop proceeds and the push is refused. The refused push sets overflow if in_valid is high.
- At EMPTY, a pop is refused and sets underflow; a simultaneous push proceeds, and count becomes 1.
- Refused pushes are dropped with no retry. The producer must hold in_valid high until in_ready is high to avoid loss.
- clear overrides push and pop in the same cycle:
  - pointers, count, checksum, overflow and underflow go to 0;
  - rd_valid=0;
  - rd_data/rd_mode hold their previous values;
  - buffer contents are not erased.
- When rd_valid=0, rd_data/rd_mode hold their last popped value.

## Timing
- Reset values: in_ready=1, rd_valid=0, rd_data=0, rd_mode=0, count=0, empty=1, full=0, overflow=0, underflow=0, checksum=0. Pointers are 0.
- Reset asserted mid-operation discards all entries immediately (asynchronous). The first accept is possible on the first rising edge after deassertion.
- in_ready, empty and full are combinational from the registered count only. They have no combinational path from in_valid or rd_req.
- Push latency: an accept at edge N updates count, checksum and full from edge N.
- Pop latency: a request sampled at edge N gives rd_valid=1 and data in the cycle after edge N, for exactly one cycle per pop.
- Back-to-back pops every cycle give one rd_valid per cycle with no bubbles.
- Throughput: one push and one pop per cycle.
- The buffer returns entries in order: each pop returns the oldest remaining entry. A push and pop of the same slot in one cycle cannot happen because of the empty rule.

## Test plan
- Reset, then push mode 3 product 128'h1 then mode 2 product 128'hFFFF…FF, then pop twice.
  - Pops return rd_data=128'h1/rd_mode=3, then 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF/rd_mode=2.
  - checksum = 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE.
- Push 16 products of value i (i=0..15, mode 0) → full=1, in_ready=0, count=16. A 17th in_valid → overflow=1 and count stays 16. Popping 16 times → values 0..15 in order, then empty=1.
- With count=5, assert in_valid and rd_req together for 10 cycles → count stays 5, and 10 rd_valid pulses return entries in order with no gaps.
- In EMPTY, assert rd_req and in_valid together (value 7) → underflow=1, no rd_valid, count=1. The next pop returns 7.
- Fill to wrap the pointers: push 12, pop 12, push 8, then pop all 8 → the 8 values come back in order across the wrap boundary.
- Mid-stream: assert clear with count=9 and in_valid high → the next cycle shows count=0, checksum=0, flags=0, and the push is ignored. Then drop reset while count=4 → all outputs take their reset values immediately, without a clock edge.

Source files
------------

// File: rtl/product_collector_if.sv
// product_collector_if
//
// Purpose: groups the product push handshake and the pop/read-back bus of the
// product collector so that producer/reader and collector share one bundle.
//
// Signals:
//   in_valid  producer -> collector  product/mode valid this cycle
//   in_ready  collector -> producer  collector can accept a product
//   product   producer -> collector  raw product from the multiplier
//   mode      producer -> collector  width mode tag (0,1: 64b, 2: 96b, 3: full)
//   rd_req    reader    -> collector  pop the oldest entry
//   rd_valid  collector -> reader     one-cycle pulse, rd_data/rd_mode valid
//   rd_data   collector -> reader     popped masked product
//   rd_mode   collector -> reader     mode tag of the popped entry
//
// Modports: master = producer/reader side, slave = collector side.

interface product_collector_if #(
    parameter int WIDTH = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] product;
    logic [1:0]       mode;
    logic             rd_req;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [1:0]       rd_mode;

    modport master (
        output in_valid,
        output product,
        output mode,
        output rd_req,
        input  in_ready,
        input  rd_valid,
        input  rd_data,
        input  rd_mode
    );

    modport slave (
        input  in_valid,
        input  product,
        input  mode,
        input  rd_req,
        output in_ready,
        output rd_valid,
        output rd_data,
        output rd_mode
    );
endinterface

// File: rtl/product_collector.sv
// product_collector
//
// Purpose: result-capture buffer at the output of the multiplier datapath.
// Each accepted product is masked to the width of its mode, stored with its
// mode tag in a DEPTH-entry in-order buffer, and folded into a running XOR
// checksum. A reader pops entries oldest-first; sticky flags record products
// dropped while full and pops attempted while empty.
//
// Ports:
//   clock      sole clock, rising edge
//   reset      asynchronous, active-low
//   clear      synchronous clear of pointers, count, checksum and flags
//   bus        product_collector_if slave (push handshake + pop read-back)
//   count      number of entries held (0..DEPTH)
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: in_valid seen while in_ready was low
//   underflow  sticky: rd_req seen while empty
//   checksum   XOR of all accepted masked products since reset/clear

module product_collector #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    product_collector_if.slave       bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow,
    output logic [WIDTH-1:0]         checksum
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_t;

    occ_state_t       occ;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   next_count;
    logic             push_ok;
    logic             pop_ok;
    logic [WIDTH-1:0] masked;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [1:0]       mem_mode [DEPTH];

    // Bits at or above the mode's result width are forced to zero.
    function automatic logic [WIDTH-1:0] mode_mask(input logic [1:0] m);
        int               keep;
        logic [WIDTH-1:0] r;
        case (m)
            2'd2:    keep = 96;
            2'd3:    keep = WIDTH;
            default: keep = 64;
        endcase
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = (i < keep);
        end
        return r;
    endfunction

    // Occupancy is decoded from the registered count only, so in_ready,
    // empty and full never depend combinationally on in_valid or rd_req.
    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0) begin
            occ = OCC_EMPTY;
        end else if (count == FULL_COUNT) begin
            occ = OCC_FULL;
        end
    end

    assign empty        = (occ == OCC_EMPTY);
    assign full         = (occ == OCC_FULL);
    assign bus.in_ready = !full;

    assign masked  = bus.product & mode_mask(bus.mode);
    assign push_ok = bus.in_valid && bus.in_ready && !clear;
    assign pop_ok  = bus.rd_req && !empty && !clear;

    always_comb begin
        next_count = count;
        case ({push_ok, pop_ok})
            2'b10:   next_count = count + (PTR_W + 1)'(1);
            2'b01:   next_count = count - (PTR_W + 1)'(1);
            default: next_count = count;
        endcase
    end

    // Storage has no reset: clear and reset only move the pointers, the
    // stale contents are unreachable until overwritten.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= masked;
            mem_mode[wr_ptr] <= bus.mode;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            checksum     <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_mode  <= '0;
        end else if (clear) begin
            // rd_data/rd_mode intentionally keep their last popped value.
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            checksum     <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            bus.rd_valid <= 1'b0;
        end else begin
            count        <= next_count;
            bus.rd_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr   <= wr_ptr + 1'b1;
                checksum <= checksum ^ masked;
            end
            if (pop_ok) begin
                rd_ptr      <= rd_ptr + 1'b1;
                bus.rd_data <= mem_data[rd_ptr];
                bus.rd_mode <= mem_mode[rd_ptr];
            end
            if (bus.in_valid && !bus.in_ready) begin
                overflow <= 1'b1;
            end
            if (bus.rd_req && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_product_collector.sv
// tb_product_collector
//
// Purpose: self-checking bench for product_collector. A queue-based reference
// model tracks the expected buffer contents, checksum, flags and read-back,
// and every driven cycle is compared against it. A table of directed vectors
// carries independently written expected values, followed by hand-written
// multi-cycle sequences and a randomized phase.

module tb_product_collector;

    localparam int DEPTH = 16;
    localparam int WIDTH = 128;

    localparam logic [127:0] ONES = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] C96  = 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] CKS1 = 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;
    localparam logic [127:0] L64  = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] AAAA = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    localparam logic [127:0] A64  = 128'h0000_0000_0000_0000_AAAA_AAAA_AAAA_AAAA;
    localparam logic [127:0] X64  = 128'h0000_0000_0000_0000_5555_5555_5555_5555;

    logic         clock = 1'b0;
    logic         reset;
    logic         clear;
    logic [4:0]   count;
    logic         empty;
    logic         full;
    logic         overflow;
    logic         underflow;
    logic [127:0] checksum;

    product_collector_if #(.WIDTH(WIDTH)) bus ();

    product_collector #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .bus       (bus),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .checksum  (checksum)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]   mode;
        logic [127:0] data;
    } entry_t;

    entry_t       mq[$];
    logic [127:0] m_cks;
    logic [127:0] m_rd_data;
    logic [1:0]   m_rd_mode;
    logic         m_rv;
    logic         m_ovf;
    logic         m_udf;

    typedef struct {
        logic         iv;
        logic [1:0]   md;
        logic [127:0] pr;
        logic         rr;
        logic         cl;
        logic [4:0]   e_count;
        logic         e_rv;
        logic [127:0] e_data;
        logic [1:0]   e_mode;
        logic [127:0] e_cks;
        logic         e_udf;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [127:0] ref_mask(input logic [1:0] md, input logic [127:0] p);
        logic [127:0] all_ones;
        all_ones = ONES;
        if (md < 2) return p & (all_ones >> 64);
        if (md == 2) return p & (all_ones >> 32);
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cks     = '0;
        m_rd_data = '0;
        m_rd_mode = '0;
        m_rv      = 1'b0;
        m_ovf     = 1'b0;
        m_udf     = 1'b0;
    endtask

    task automatic model_step(input logic iv, input logic [1:0] md, input logic [127:0] pr,
                              input logic rr, input logic cl);
        int     n;
        entry_t e;
        if (cl) begin
            mq.delete();
            m_cks = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rv  = 1'b0;
            return;
        end
        n    = mq.size();
        m_rv = 1'b0;
        if (rr) begin
            if (n == 0) begin
                m_udf = 1'b1;
            end else begin
                e         = mq.pop_front();
                m_rv      = 1'b1;
                m_rd_data = e.data;
                m_rd_mode = e.mode;
            end
        end
        if (iv) begin
            if (n == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                e.mode = md;
                e.data = ref_mask(md, pr);
                mq.push_back(e);
                m_cks = m_cks ^ e.data;
            end
        end
    endtask

    task automatic checkValue(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        int n;
        n = mq.size();
        checkValue({tag, ".count"},     128'(count),         128'(n));
        checkValue({tag, ".empty"},     128'(empty),         128'(n == 0));
        checkValue({tag, ".full"},      128'(full),          128'(n == DEPTH));
        checkValue({tag, ".in_ready"},  128'(bus.in_ready),  128'(n != DEPTH));
        checkValue({tag, ".overflow"},  128'(overflow),      128'(m_ovf));
        checkValue({tag, ".underflow"}, 128'(underflow),     128'(m_udf));
        checkValue({tag, ".checksum"},  checksum,            m_cks);
        checkValue({tag, ".rd_valid"},  128'(bus.rd_valid),  128'(m_rv));
        checkValue({tag, ".rd_data"},   bus.rd_data,         m_rd_data);
        checkValue({tag, ".rd_mode"},   128'(bus.rd_mode),   128'(m_rd_mode));
    endtask

    task automatic applyStimulus(input logic iv, input logic [1:0] md, input logic [127:0] pr,
                                 input logic rr, input logic cl, input string tag);
        bus.in_valid = iv;
        bus.mode     = md;
        bus.product  = pr;
        bus.rd_req   = rr;
        clear        = cl;
        @(posedge clock);
        model_step(iv, md, pr, rr, cl);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int pulses;
        int iv_pct;
        int rr_pct;
        logic [127:0] exp_v;

        vecs[0]  = '{1'b1, 2'd3, 128'h1, 1'b0, 1'b0, 5'd1, 1'b0, 128'h0, 2'd0, 128'h1, 1'b0};
        vecs[1]  = '{1'b1, 2'd2, ONES,   1'b0, 1'b0, 5'd2, 1'b0, 128'h0, 2'd0, CKS1,   1'b0};
        vecs[2]  = '{1'b0, 2'd0, 128'h0, 1'b1, 1'b0, 5'd1, 1'b1, 128'h1, 2'd3, CKS1,   1'b0};
        vecs[3]  = '{1'b0, 2'd0, 128'h0, 1'b1, 1'b0, 5'd0, 1'b1, C96,    2'd2, CKS1,   1'b0};
        vecs[4]  = '{1'b0, 2'd0, 128'h0, 1'b0, 1'b0, 5'd0, 1'b0, C96,    2'd2, CKS1,   1'b0};
        vecs[5]  = '{1'b0, 2'd0, 128'h0, 1'b1, 1'b0, 5'd0, 1'b0, C96,    2'd2, CKS1,   1'b1};
        vecs[6]  = '{1'b0, 2'd0, 128'h0, 1'b0, 1'b1, 5'd0, 1'b0, C96,    2'd2, 128'h0, 1'b0};
        vecs[7]  = '{1'b1, 2'd1, ONES,   1'b0, 1'b0, 5'd1, 1'b0, C96,    2'd2, L64,    1'b0};
        vecs[8]  = '{1'b1, 2'd0, AAAA,   1'b0, 1'b0, 5'd2, 1'b0, C96,    2'd2, X64,    1'b0};
        vecs[9]  = '{1'b0, 2'd0, 128'h0, 1'b1, 1'b0, 5'd1, 1'b1, L64,    2'd1, X64,    1'b0};
        vecs[10] = '{1'b0, 2'd0, 128'h0, 1'b1, 1'b0, 5'd0, 1'b1, A64,    2'd0, X64,    1'b0};

        reset        = 1'b0;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.mode     = 2'd0;
        bus.product  = '0;
        bus.rd_req   = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("reset_state");

        // directed vector table
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].md, vecs[i].pr, vecs[i].rr, vecs[i].cl,
                          $sformatf("vec%0d", i));
            checkValue($sformatf("vec%0d.t_count", i), 128'(count), 128'(vecs[i].e_count));
            checkValue($sformatf("vec%0d.t_rv", i), 128'(bus.rd_valid), 128'(vecs[i].e_rv));
            checkValue($sformatf("vec%0d.t_data", i), bus.rd_data, vecs[i].e_data);
            checkValue($sformatf("vec%0d.t_mode", i), 128'(bus.rd_mode), 128'(vecs[i].e_mode));
            checkValue($sformatf("vec%0d.t_cks", i), checksum, vecs[i].e_cks);
            checkValue($sformatf("vec%0d.t_udf", i), 128'(underflow), 128'(vecs[i].e_udf));
        end

        // fill to full, overflow, drain in order
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd0, 128'(i), 1'b0, 1'b0, "fill");
        checkValue("fill.full", 128'(full), 128'(1));
        checkValue("fill.in_ready", 128'(bus.in_ready), 128'(0));
        checkValue("fill.count", 128'(count), 128'(16));
        applyStimulus(1'b1, 2'd0, 128'd99, 1'b0, 1'b0, "overfill");
        checkValue("overfill.overflow", 128'(overflow), 128'(1));
        checkValue("overfill.count", 128'(count), 128'(16));
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 2'd0, 128'h0, 1'b1, 1'b0, "drain");
            checkValue("drain.order", bus.rd_data, 128'(i));
        end
        checkValue("drain.empty", 128'(empty), 128'(1));
        applyStimulus(1'b0, 2'd0, 128'h0, 1'b0, 1'b1, "clear1");

        // steady push+pop at count 5
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd3, 128'(100 + i), 1'b0, 1'b0, "pre5");
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 2'd3, 128'(200 + i), 1'b1, 1'b0, "pushpop");
            if (bus.rd_valid) pulses++;
            exp_v = (i < 5) ? 128'(100 + i) : 128'(200 + i - 5);
            checkValue("pushpop.count", 128'(count), 128'(5));
            checkValue("pushpop.data", bus.rd_data, exp_v);
        end
        checkValue("pushpop.pulses", 128'(pulses), 128'(10));
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd0, 128'h0, 1'b1, 1'b0, "post5");
        applyStimulus(1'b0, 2'd0, 128'h0, 1'b0, 1'b1, "clear2");

        // pop and push together while empty
        applyStimulus(1'b1, 2'd0, 128'd7, 1'b1, 1'b0, "emptyboth");
        checkValue("emptyboth.underflow", 128'(underflow), 128'(1));
        checkValue("emptyboth.rd_valid", 128'(bus.rd_valid), 128'(0));
        checkValue("emptyboth.count", 128'(count), 128'(1));
        applyStimulus(1'b0, 2'd0, 128'h0, 1'b1, 1'b0, "emptypop");
        checkValue("emptypop.data", bus.rd_data, 128'd7);
        applyStimulus(1'b0, 2'd0, 128'h0, 1'b0, 1'b1, "clear3");

        // pointer wrap
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 2'd2, 128'(300 + i), 1'b0, 1'b0, "wrap_push12");
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 2'd0, 128'h0, 1'b1, 1'b0, "wrap_pop12");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'd1, 128'(400 + i), 1'b0, 1'b0, "wrap_push8");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 2'd0, 128'h0, 1'b1, 1'b0, "wrap_pop8");
            checkValue("wrap.order", bus.rd_data, 128'(400 + i));
        end

        // clear mid-stream with a push pending
        applyStimulus(1'b0, 2'd0, 128'h0, 1'b1, 1'b0, "udf_set");
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 2'd3, 128'(500 + i), 1'b0, 1'b0, "pre9");
        applyStimulus(1'b1, 2'd3, 128'd55, 1'b0, 1'b1, "clear9");
        checkValue("clear9.count", 128'(count), 128'(0));
        checkValue("clear9.checksum", checksum, 128'h0);
        checkValue("clear9.underflow", 128'(underflow), 128'(0));
        checkValue("clear9.overflow", 128'(overflow), 128'(0));
        applyStimulus(1'b0, 2'd0, 128'h0, 1'b0, 1'b0, "postclear");

        // asynchronous reset with count 4
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd3, 128'(600 + i), 1'b0, 1'b0, "pre4");
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkValue("areset.count", 128'(count), 128'(0));
        checkValue("areset.empty", 128'(empty), 128'(1));
        checkValue("areset.full", 128'(full), 128'(0));
        checkValue("areset.in_ready", 128'(bus.in_ready), 128'(1));
        checkValue("areset.checksum", checksum, 128'h0);
        checkValue("areset.rd_valid", 128'(bus.rd_valid), 128'(0));
        checkValue("areset.rd_data", bus.rd_data, 128'h0);
        checkValue("areset.rd_mode", 128'(bus.rd_mode), 128'(0));
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(1'b1, 2'd3, 128'd1, 1'b0, 1'b0, "first_accept");
        checkValue("first_accept.count", 128'(count), 128'(1));

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            iv_pct = (i < 200) ? 70 : 30;
            rr_pct = (i < 200) ? 30 : 70;
            applyStimulus(($urandom_range(0, 99) < iv_pct), 2'($urandom_range(0, 3)),
                          {$urandom, $urandom, $urandom, $urandom},
                          ($urandom_range(0, 99) < rr_pct), ($urandom_range(0, 99) < 2), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
